// File: rtl/mvm_pkg.sv
// Shared types and constants for the matrix-vector multiply control stage.
package mvm_pkg;

   typedef enum logic [1:0] {
      LOAD_MAT,
      LOAD_VEC,
      COMPUTE,
      OUTPUT
   } mvm_state_t;

   localparam int DEF_INW  = 16;
   localparam int DEF_OUTW = 48;
   localparam int DEF_M    = 4;
   localparam int DEF_N    = 4;

   // Address width for a memory of the given depth; never narrower than one bit.
   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int DEF_MAT_AW = addr_w(DEF_M * DEF_N);
   localparam int DEF_VEC_AW = addr_w(DEF_N);

endpackage

// File: rtl/mvm_mem.sv
// Single-port memory with synchronous read; the array maps onto block RAM.
module mvm_mem
   import mvm_pkg::*;
#(
   parameter int WIDTH = DEF_INW,
   parameter int DEPTH = DEF_M * DEF_N,
   parameter int AW    = addr_w(DEPTH)
)(
   input  logic             clk,
   input  logic [AW-1:0]    addr,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[addr] <= wr_data;
      rd_data <= mem[addr];
   end

endmodule

// File: rtl/mvm_ctrl.sv
// Operand storage and row-by-row MAC sequencing for the matrix-vector multiply.
// Define MVM_CTRL_RELU_EN to clamp negative row results to zero on capture.
module mvm_ctrl
   import mvm_pkg::*;
#(
   parameter int INW  = DEF_INW,
   parameter int OUTW = DEF_OUTW,
   parameter int M    = DEF_M,
   parameter int N    = DEF_N
)(
   input  logic            clk,
   input  logic            reset,
   input  logic [INW-1:0]  in_data,
   input  logic            in_new_matrix,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [INW-1:0]  mac_in0,
   output logic [INW-1:0]  mac_in1,
   output logic            mac_valid_input,
   output logic            mac_clear_acc,
   input  logic [OUTW-1:0] mac_out,
   output logic [OUTW-1:0] out_data,
   output logic            out_valid,
   input  logic            out_ready
);

   localparam int MN  = M * N;
   localparam int MAW = addr_w(MN);
   localparam int VAW = addr_w(N);
   localparam int RAW = addr_w(M);
   localparam int CW  = addr_w(MN + 3);

   mvm_state_t     state_reg, state_next;
   logic           first_reg;
   logic [MAW-1:0] ld_cnt_reg;
   logic [CW-1:0]  iss_cnt_reg;
   logic [RAW-1:0] iss_row_reg;
   logic [VAW-1:0] iss_col_reg;
   logic [RAW-1:0] k_reg;

   // Issue-to-capture pipeline: stage 1 = operands, 2 = clear, 3 = capture.
   logic           v1_reg, first1_reg, last1_reg;
   logic [RAW-1:0] row1_reg, row2_reg, row3_reg;
   logic           clr_reg, last2_reg, cap_reg;

   logic [OUTW-1:0] result_buf [M];
   logic [OUTW-1:0] cap_data;

   logic           accept, is_mat_word, is_vec_word, mat_last, vec_last;
   logic           issuing, out_done;
   logic [MAW-1:0] mat_addr;
   logic [VAW-1:0] vec_addr;
   logic [INW-1:0] mat_rd, vec_rd;

   assign accept      = in_valid && in_ready;
   // A first word without new_matrix is already vector element 0.
   assign is_vec_word = accept && ((state_reg == LOAD_VEC) ||
                                   (state_reg == LOAD_MAT && first_reg && !in_new_matrix));
   assign is_mat_word = accept && (state_reg == LOAD_MAT) && !(first_reg && !in_new_matrix);
   assign mat_last    = is_mat_word && (ld_cnt_reg == MAW'(MN - 1));
   assign vec_last    = is_vec_word && (ld_cnt_reg == MAW'(N - 1));
   assign issuing     = (state_reg == COMPUTE) && (iss_cnt_reg < CW'(MN));
   assign out_done    = (state_reg == OUTPUT) && out_ready && (k_reg == RAW'(M - 1));

   always_comb begin
      state_next      = state_reg;
      in_ready        = 1'b0;
      out_valid       = 1'b0;
      out_data        = '0;
      mac_valid_input = v1_reg;
      mac_clear_acc   = clr_reg;
      mac_in0         = v1_reg ? mat_rd : '0;
      mac_in1         = v1_reg ? vec_rd : '0;
      case (state_reg)
         LOAD_MAT: begin
            in_ready = !reset;
            if (vec_last)
               state_next = COMPUTE;
            else if (is_vec_word || mat_last)
               state_next = LOAD_VEC;
         end
         LOAD_VEC: begin
            in_ready = !reset;
            if (vec_last)
               state_next = COMPUTE;
         end
         COMPUTE: begin
            if (iss_cnt_reg == CW'(MN + 2))
               state_next = OUTPUT;
         end
         OUTPUT: begin
            out_valid = 1'b1;
            out_data  = result_buf[k_reg];
            if (out_done)
               state_next = LOAD_MAT;
         end
         default: state_next = LOAD_MAT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= LOAD_MAT;
         first_reg  <= 1'b1;
         ld_cnt_reg <= '0;
         k_reg      <= '0;
      end else begin
         state_reg <= state_next;
         if (accept)
            first_reg <= 1'b0;
         else if (out_done)
            first_reg <= 1'b1;
         if (is_mat_word)
            ld_cnt_reg <= mat_last ? '0 : ld_cnt_reg + MAW'(1);
         else if (is_vec_word)
            ld_cnt_reg <= vec_last ? '0 : ld_cnt_reg + MAW'(1);
         if (state_reg == OUTPUT && out_ready)
            k_reg <= (k_reg == RAW'(M - 1)) ? '0 : k_reg + RAW'(1);
      end
   end

   // Issue counters run only while in COMPUTE and restart at every entry.
   always_ff @(posedge clk) begin
      if (reset || state_reg != COMPUTE) begin
         iss_cnt_reg <= '0;
         iss_row_reg <= '0;
         iss_col_reg <= '0;
      end else begin
         iss_cnt_reg <= iss_cnt_reg + CW'(1);
         if (issuing) begin
            if (iss_col_reg == VAW'(N - 1)) begin
               iss_col_reg <= '0;
               iss_row_reg <= iss_row_reg + RAW'(1);
            end else begin
               iss_col_reg <= iss_col_reg + VAW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v1_reg     <= 1'b0;
         first1_reg <= 1'b0;
         last1_reg  <= 1'b0;
         row1_reg   <= '0;
         clr_reg    <= 1'b0;
         last2_reg  <= 1'b0;
         row2_reg   <= '0;
         cap_reg    <= 1'b0;
         row3_reg   <= '0;
      end else begin
         v1_reg     <= issuing;
         first1_reg <= issuing && (iss_col_reg == '0);
         last1_reg  <= issuing && (iss_col_reg == VAW'(N - 1));
         row1_reg   <= iss_row_reg;
         clr_reg    <= first1_reg;
         last2_reg  <= last1_reg;
         row2_reg   <= row1_reg;
         cap_reg    <= last2_reg;
         row3_reg   <= row2_reg;
      end
   end

`ifdef MVM_CTRL_RELU_EN
   assign cap_data = mac_out[OUTW-1] ? '0 : mac_out;
`else
   assign cap_data = mac_out;
`endif

   for (genvar gi = 0; gi < M; gi++) begin : g_res
      always_ff @(posedge clk) begin
         if (cap_reg && row3_reg == RAW'(gi))
            result_buf[gi] <= cap_data;
      end
   end

   assign mat_addr = (state_reg == COMPUTE) ? iss_cnt_reg[MAW-1:0] : ld_cnt_reg;
   assign vec_addr = (state_reg == COMPUTE) ? iss_col_reg : ld_cnt_reg[VAW-1:0];

   mvm_mem #(.WIDTH(INW), .DEPTH(MN), .AW(MAW)) u_mat_mem (
      .clk     (clk),
      .addr    (mat_addr),
      .wr_en   (is_mat_word),
      .wr_data (in_data),
      .rd_data (mat_rd)
   );

   mvm_mem #(.WIDTH(INW), .DEPTH(N), .AW(VAW)) u_vec_mem (
      .clk     (clk),
      .addr    (vec_addr),
      .wr_en   (is_vec_word),
      .wr_data (in_data),
      .rd_data (vec_rd)
   );

endmodule

// File: tb/tb_mvm_ctrl.sv
// Directed bench for mvm_ctrl with a behavioural two-stage saturating MAC and a result scoreboard.
module tb_mvm_ctrl;
   import mvm_pkg::*;

   localparam int INW  = 16;
   localparam int OUTW = 32;
   localparam int M    = 4;
   localparam int N    = 4;
   localparam int SW   = OUTW + 1;

   logic            clk = 1'b0;
   logic            reset;
   logic [INW-1:0]  in_data;
   logic            in_new_matrix, in_valid, in_ready;
   logic [INW-1:0]  mac_in0, mac_in1;
   logic            mac_valid_input, mac_clear_acc;
   logic [OUTW-1:0] mac_out;
   logic [OUTW-1:0] out_data;
   logic            out_valid, out_ready;

   int n_checks = 0;
   int n_fail   = 0;

   logic signed [INW-1:0] w_m [M][N];
   logic signed [INW-1:0] x_v [N];
   logic [OUTW-1:0]       exp_q [$];

   always #5 clk = ~clk;

   mvm_ctrl #(.INW(INW), .OUTW(OUTW), .M(M), .N(N)) dut (
      .clk             (clk),
      .reset           (reset),
      .in_data         (in_data),
      .in_new_matrix   (in_new_matrix),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .mac_in0         (mac_in0),
      .mac_in1         (mac_in1),
      .mac_valid_input (mac_valid_input),
      .mac_clear_acc   (mac_clear_acc),
      .mac_out         (mac_out),
      .out_data        (out_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready)
   );

   function automatic logic signed [OUTW-1:0] mul(input logic signed [INW-1:0] a,
                                                  input logic signed [INW-1:0] b);
      logic signed [OUTW-1:0] ae, be;
      ae = OUTW'(a);
      be = OUTW'(b);
      return ae * be;
   endfunction

   function automatic logic signed [OUTW-1:0] sat_add(input logic signed [OUTW-1:0] a,
                                                      input logic signed [OUTW-1:0] b);
      logic signed [SW-1:0] s;
      s = SW'(a) + SW'(b);
      if (s[OUTW] != s[OUTW-1])
         return s[OUTW] ? $signed({1'b1, {(OUTW-1){1'b0}}}) : $signed({1'b0, {(OUTW-1){1'b1}}});
      return $signed(s[OUTW-1:0]);
   endfunction

   // MAC: product registered, then accumulated (or restarted on clear) one cycle later.
   logic signed [OUTW-1:0] prod_reg, acc_reg;
   logic                   pv_reg;
   always_ff @(posedge clk) begin
      if (reset) begin
         prod_reg <= '0;
         pv_reg   <= 1'b0;
         acc_reg  <= '0;
      end else begin
         prod_reg <= mul(mac_in0, mac_in1);
         pv_reg   <= mac_valid_input;
         if (pv_reg)
            acc_reg <= mac_clear_acc ? prod_reg : sat_add(acc_reg, prod_reg);
      end
   end
   assign mac_out = acc_reg;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic send_word(input logic [INW-1:0] d, input logic nm);
      int t = 0;
      in_data       = d;
      in_new_matrix = nm;
      in_valid      = 1'b1;
      while (!in_ready && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 100) chk("in_ready_timeout", 64'(t), 64'(0));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Pushes the golden results (if requested) and streams the words of one transaction.
   task automatic send_txn(input logic nm, input bit push);
      logic signed [OUTW-1:0] acc;
      if (push) begin
         for (int r = 0; r < M; r++) begin
            acc = '0;
            for (int c = 0; c < N; c++)
               acc = (c == 0) ? mul(w_m[r][c], x_v[c]) : sat_add(acc, mul(w_m[r][c], x_v[c]));
`ifdef MVM_CTRL_RELU_EN
            if (acc < 0) acc = '0;
`endif
            exp_q.push_back(acc);
         end
      end
      if (nm)
         for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
               send_word(w_m[r][c], (r == 0 && c == 0));
      for (int c = 0; c < N; c++)
         send_word(x_v[c], nm ? 1'b0 : (c != 0));
   endtask

   // Called in the COMPUTE entry cycle; holds a word at the input to show it is refused.
   task automatic wait_compute();
      int t = 0, nv = 0, nc = 0, rdy = 0;
      chk("in_ready_after_vector", in_ready, 1'b0);
      in_valid      = 1'b1;
      in_data       = '1;
      in_new_matrix = 1'b1;
      while (!out_valid && t < 200) begin
         if (mac_valid_input) nv++;
         if (mac_clear_acc) nc++;
         if (in_ready) rdy++;
         @(posedge clk); #1;
         t++;
      end
      in_valid = 1'b0;
      chk("out_valid_latency", 64'(t), 64'(M * N + 3));
      chk("mac_valid_cycles", 64'(nv), 64'(M * N));
      chk("mac_clear_cycles", 64'(nc), 64'(M));
      chk("in_ready_in_compute", 64'(rdy), 64'(0));
   endtask

   task automatic collect(input int stall);
      logic [OUTW-1:0] held, expv;
      for (int k = 0; k < M; k++) begin
         int t = 0;
         while (!out_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
         end
         chk("out_valid_wait", out_valid, 1'b1);
         if (k == 0 && stall > 0) begin
            out_ready = 1'b0;
            held      = out_data;
            for (int i = 0; i < stall; i++) begin
               @(posedge clk); #1;
               chk("bp_data_stable", out_data, held);
               chk("bp_valid_held", out_valid, 1'b1);
               chk("bp_in_ready", in_ready, 1'b0);
            end
         end
         out_ready = 1'b1;
         if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 64'(1), 64'(0));
            expv = '0;
         end else begin
            expv = exp_q.pop_front();
         end
         chk("result", out_data, expv);
         @(posedge clk); #1;
      end
      chk("done_out_valid", out_valid, 1'b0);
      chk("done_in_ready", in_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b1;
      in_data       = '0;
      in_new_matrix = 1'b0;
      in_valid      = 1'b0;
      out_ready     = 1'b1;

      // Reset state
      @(posedge clk); #1;
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, '0);
      chk("rst_mac_valid", mac_valid_input, 1'b0);
      chk("rst_mac_clear", mac_clear_acc, 1'b0);
      chk("rst_mac_in0", mac_in0, '0);
      chk("rst_mac_in1", mac_in1, '0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_in_ready", in_ready, 1'b1);

      // Identity matrix
      for (int r = 0; r < M; r++)
         for (int c = 0; c < N; c++)
            w_m[r][c] = (r == c) ? 16'sd1 : 16'sd0;
      for (int c = 0; c < N; c++) x_v[c] = 16'(c + 1);
      send_txn(1'b1, 1'b1);
      wait_compute();
      collect(0);
      $display("identity transaction done");

      // Load all-2 matrix, then reuse it with a vector-only transaction
      for (int r = 0; r < M; r++)
         for (int c = 0; c < N; c++)
            w_m[r][c] = 16'sd2;
      send_txn(1'b1, 1'b1);
      wait_compute();
      collect(0);
      for (int c = 0; c < N; c++) x_v[c] = 16'sd1;
      send_txn(1'b0, 1'b1);
      wait_compute();
      collect(0);
      $display("matrix reuse transaction done");

      // Saturation passthrough
      for (int r = 0; r < M; r++)
         for (int c = 0; c < N; c++)
            w_m[r][c] = 16'h7FFF;
      for (int c = 0; c < N; c++) x_v[c] = 16'h7FFF;
      send_txn(1'b1, 1'b1);
      wait_compute();
      collect(0);
      $display("saturation transaction done");

      // Backpressure with random operands
      for (int r = 0; r < M; r++)
         for (int c = 0; c < N; c++)
            w_m[r][c] = 16'($urandom);
      for (int c = 0; c < N; c++) x_v[c] = 16'($urandom);
      send_txn(1'b1, 1'b1);
      wait_compute();
      collect(10);
      $display("backpressure transaction done");

      // Reset in the middle of COMPUTE
      send_txn(1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      chk("midrst_mac_valid", mac_valid_input, 1'b0);
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_in_ready", in_ready, 1'b0);
      chk("midrst_mac_in0", mac_in0, '0);
      reset = 1'b0;
      #1;
      chk("midrst_load_mat", in_ready, 1'b1);
      for (int r = 0; r < M; r++)
         for (int c = 0; c < N; c++)
            w_m[r][c] = 16'($urandom_range(0, 200)) - 16'sd100;
      for (int c = 0; c < N; c++) x_v[c] = 16'($urandom_range(0, 200)) - 16'sd100;
      send_txn(1'b1, 1'b1);
      wait_compute();
      collect(0);
      $display("reset recovery transaction done");

      // Negative row result (clamped to zero in the ReLU build)
      for (int c = 0; c < N; c++) w_m[0][c] = -16'sd1;
      for (int c = 0; c < N; c++) x_v[c] = 16'sd1;
      send_txn(1'b1, 1'b1);
      wait_compute();
      collect(0);
      $display("negative row transaction done");

      chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mvm_ctrl.md
# mvm_ctrl

Control and operand-storage stage sitting directly upstream of the pipelined saturating MAC in the matrix-vector multiply datapath. Accepts a matrix (optional reload) and a vector over a valid/ready input stream, stores them in on-chip memories, sequences the MAC (operands, valid, clear) row by row, captures each row result and streams the M results out over a valid/ready output.

## Interface
- INW, 16: operand width, signed
- OUTW, 48: accumulator/result width, signed
- M, 4: matrix rows (= number of results)
- N, 4: matrix columns (= vector length)

- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- in_data  in  INW  input word (matrix row-major, then vector)
- in_new_matrix  in  1  sampled with the first word of a transaction only
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts word
- mac_in0, mac_in1  out  INW  matrix / vector operands to MAC
- mac_valid_input  out  1  operands valid this cycle
- mac_clear_acc  out  1  start new accumulation
- mac_out  in  OUTW  MAC accumulator value
- out_data  out  OUTW  result word
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result

## Operation
- States: LOAD_MAT, LOAD_VEC, COMPUTE, OUTPUT. Reset -> LOAD_MAT with first-word flag set.
- Transaction start: first accepted word with in_new_matrix=1 -> LOAD_MAT, store M*N words row-major, then LOAD_VEC for N words. With in_new_matrix=0 -> word is vector[0], matrix memory untouched. in_new_matrix ignored on non-first words.
- in_ready=1 only in LOAD_MAT/LOAD_VEC; word accepted when in_valid&in_ready.
- After vector word N-1 accepted -> COMPUTE. For row r=0..M-1, column c=0..N-1: read W[r][c], x[c]; present on mac_in0/mac_in1 with mac_valid_input=1. No bubbles between rows.
- mac_clear_acc=1 in the cycle after the operands of c=0 are presented, else 0.
- Row result captured from mac_out two cycles after operands of c=N-1 are presented; written to result buffer slot r.
- After row M-1 captured -> OUTPUT; out_valid=1, out_data=result[k], k advances on out_valid&out_ready. After k=M-1 handshake -> LOAD_MAT (awaiting first word), first-word flag set.
- mac_valid_input=0 and operands hold 0 outside COMPUTE issue cycles.
- Saturation is done by the MAC; mvm_ctrl passes mac_out unmodified (except Configuration).

## Timing
- Reset values: in_ready=0 during reset cycle, 1 from first cycle after; out_valid=0, out_data=0, mac_valid_input=0, mac_clear_acc=0, mac_in0=mac_in1=0; all counters 0.
- Memories are synchronous-read: address issued cycle t, operands on mac_in* in t+1; mac_valid_input is registered to align.
- Issue of row r, col c (address cycle) at COMPUTE entry + r*N + c; operands one cycle later; clear one cycle after that for c=0.
- COMPUTE length: M*N + 3 cycles from entry to OUTPUT (1 read + 2 MAC).
- out_valid held with stable out_data until accepted; no combinational path from out_ready to in_ready.
- Reset mid-transaction: abort, return to LOAD_MAT, matrix memory contents undefined (a new_matrix load is required), out_valid drops next cycle.
- in_valid during COMPUTE/OUTPUT: not accepted (in_ready=0), word held upstream.

## Configuration
- MVM_CTRL_RELU_EN defined: captured results with sign bit 1 are stored as 0 (ReLU on output). Not defined: results stored exactly as mac_out. Control timing identical in both builds.

## Structure
- Package mvm_pkg: state enum (LOAD_MAT, LOAD_VEC, COMPUTE, OUTPUT), default INW/OUTW/M/N constants, address-width helper ($clog2) constants.
- Sub-module mvm_mem: single-port synchronous memory (WIDTH, DEPTH params; addr, wr_en, wr_data, rd_data), instantiated twice (matrix M*N, vector N).
- Result buffer (M x OUTW) and counters live in mvm_ctrl.

## Test plan
- Identity 4x4 matrix, vector {1,2,3,4}, new_matrix=1 -> outputs 1,2,3,4 in order; out_valid first asserted 16+3 cycles after COMPUTE entry.
- Reuse matrix: prior W all 2s, send vector {1,1,1,1} with new_matrix=0 -> outputs 8,8,8,8; only 4 input words accepted.
- Saturation passthrough: W all 0x7FFF, x all 0x7FFF, OUTW=32 -> each result equals 0x7FFFFFFF as presented by MAC.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0; then accept 4 results one per cycle.
- Reset asserted mid-COMPUTE -> next cycle mac_valid_input=0, out_valid=0, state LOAD_MAT; fresh transaction yields correct results.
- With MVM_CTRL_RELU_EN: W row0 all -1, x {1,1,1,1} -> result0 = 0; without macro -> result0 = -4.
